// File: rtl/pooling_pkg.sv
// Shared definitions for the pooling controller and the pooling ALU it drives:
// per-lane ALU control codes, controller state encoding and config helpers.
package pooling_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_HORIZ,
    ST_OUT,
    ST_FIN
  } state_t;

  localparam logic [3:0] CTRL_HOLD     = 4'b0000;
  localparam logic [3:0] CTRL_LOAD     = 4'b0001;
  localparam logic [3:0] CTRL_MAX_IP   = 4'b0010;
  localparam logic [3:0] CTRL_MAX_DOWN = 4'b1000;

  // A window can never be wider than the lane array, so wider requests saturate.
  function automatic logic [1:0] clamp_win_w_log2(input logic [1:0] req, input int lim);
    logic [1:0] res;
    res = req;
    if ((lim < 3) && (int'(req) > lim)) begin
      res = 2'(lim);
    end
    return res;
  endfunction

endpackage

// File: rtl/pooling_controller_if.sv
// Lane-data handshake and result bus between the pooling controller (master)
// and the pooling unit / downstream consumer (slave).
interface pooling_controller_if #(
  parameter int D = 8
);
  logic           in_valid;
  logic           in_ready;
  logic           doPooling;
  logic [D*4-1:0] control;
  logic           out_valid;
  logic           out_ready;
  logic [D-1:0]   out_lane_mask;

  modport master (
    input  in_valid, out_ready,
    output in_ready, doPooling, control, out_valid, out_lane_mask
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, doPooling, control, out_valid, out_lane_mask
  );
endinterface

// File: rtl/pooling_controller.sv
// Sequences a D-lane max-pooling unit: vertical accumulation over win_h beats,
// a horizontal reduction of win_w lanes, then a held result until accepted.
module pooling_controller
  import pooling_pkg::*;
#(
  parameter int depth = 3,
  parameter int D     = (1 << depth)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [1:0]            cfg_win_h,
  input  logic [1:0]            cfg_win_w_log2,
  input  logic [15:0]           cfg_num_win,
  pooling_controller_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  state_t      state_reg, state_next;
  logic [1:0]  win_h_m1_reg, win_h_m1_next;
  logic [1:0]  win_w_log2_reg, win_w_log2_next;
  logic [15:0] num_win_reg, num_win_next;
  logic [1:0]  beat_cnt_reg, beat_cnt_next;
  logic [2:0]  horiz_cnt_reg, horiz_cnt_next;

  logic        in_ready;
  logic        beat;
  logic [3:0]  ctrl_code;
  logic [2:0]  horiz_last;
  logic [31:0] lane_low_mask;
  state_t      after_vert;

  assign in_ready      = (state_reg == ST_LOAD) || (state_reg == ST_ACCUM);
  assign beat          = bus.in_valid && in_ready;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_FIN);
  assign horiz_last    = 3'((4'd1 << win_w_log2_reg) - 4'd2);
  assign lane_low_mask = (32'd1 << win_w_log2_reg) - 32'd1;
  assign after_vert    = (win_w_log2_reg != 2'd0) ? ST_HORIZ : ST_OUT;

  assign bus.in_ready  = in_ready;
  assign bus.doPooling = (state_reg == ST_OUT);
  assign bus.out_valid = (state_reg == ST_OUT);

  always_comb begin
    state_next      = state_reg;
    win_h_m1_next   = win_h_m1_reg;
    win_w_log2_next = win_w_log2_reg;
    num_win_next    = num_win_reg;
    beat_cnt_next   = beat_cnt_reg;
    horiz_cnt_next  = horiz_cnt_reg;
    ctrl_code       = CTRL_HOLD;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          win_h_m1_next   = cfg_win_h;
          win_w_log2_next = clamp_win_w_log2(cfg_win_w_log2, depth);
          num_win_next    = cfg_num_win;
          state_next      = (cfg_num_win == 16'd0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        beat_cnt_next  = 2'd0;
        horiz_cnt_next = 3'd0;
        if (beat) begin
          ctrl_code  = CTRL_LOAD;
          state_next = (win_h_m1_reg != 2'd0) ? ST_ACCUM : after_vert;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          ctrl_code = CTRL_MAX_IP;
          if (beat_cnt_reg == win_h_m1_reg - 2'd1) begin
            state_next = after_vert;
          end else begin
            beat_cnt_next = beat_cnt_reg + 2'd1;
          end
        end
      end
      ST_HORIZ: begin
        // Reduction runs unconditionally; the unit needs no input data here.
        ctrl_code = CTRL_MAX_DOWN;
        if (horiz_cnt_reg == horiz_last) begin
          state_next = ST_OUT;
        end else begin
          horiz_cnt_next = horiz_cnt_reg + 3'd1;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          num_win_next = num_win_reg - 16'd1;
          state_next   = (num_win_reg == 16'd1) ? ST_FIN : ST_LOAD;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_IDLE;
      win_h_m1_reg   <= 2'd0;
      win_w_log2_reg <= 2'd0;
      num_win_reg    <= 16'd0;
      beat_cnt_reg   <= 2'd0;
      horiz_cnt_reg  <= 3'd0;
    end else begin
      state_reg      <= state_next;
      win_h_m1_reg   <= win_h_m1_next;
      win_w_log2_reg <= win_w_log2_next;
      num_win_reg    <= num_win_next;
      beat_cnt_reg   <= beat_cnt_next;
      horiz_cnt_reg  <= horiz_cnt_next;
    end
  end

  // Lane gi holds a window maximum when it is the leftmost lane of its window.
  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    localparam logic [31:0] LANE = gi;
    assign bus.control[4*gi +: 4]  = ctrl_code;
    assign bus.out_lane_mask[gi]   = busy && ((LANE & lane_low_mask) == 32'd0);
  end

endmodule
